// File: rtl/gate_stepper_ctrl.sv
// Programmable stepper-coil sequencer for the gate barrier motor: counted full/half-step moves.
// Define GATE_STEPPER_POS_EN to add the absolute position output pos.
module gate_stepper_ctrl #(
    parameter int unsigned PHASES     = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned CNT_W      = 12,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [CNT_W-1:0]  steps,
    input  logic [DIV_W-1:0]  rate,
    input  logic              half_step,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              dir_out,
`ifdef GATE_STEPPER_POS_EN
    output logic [CNT_W-1:0]  pos,
`endif
    output logic [PHASES-1:0] coils
);

    localparam int unsigned NIDX = 2 * PHASES;
    localparam int unsigned IW   = $clog2(NIDX);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [DIV_W-1:0]   rate_q, rate_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               half_q, half_d;
    logic [PHASES-1:0]  coils_q;
    logic               tick;

    // Even index energises one coil, odd index energises the two neighbours.
    function automatic logic [PHASES-1:0] coil_pat(input logic [IW-1:0] i);
        logic [PHASES-1:0] p;
        int unsigned       lo;
        lo = 32'(i) >> 1;
        for (int unsigned k = 0; k < PHASES; k++) begin
            p[k] = (k == lo) || (i[0] && (k == ((lo + 1) % PHASES)));
        end
        return ACTIVE_LOW ? ~p : p;
    endfunction

    function automatic logic [IW-1:0] step_idx(input logic [IW-1:0] i, input logic d,
                                               input int unsigned s);
        int unsigned v;
        v = d ? (32'(i) + NIDX - s) : (32'(i) + s);
        if (v >= NIDX) v = v - NIDX;
        return IW'(v);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        rate_d  = rate_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        half_d  = half_q;
        tick    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && (steps != '0)) begin
                    state_d = StRun;
                    dir_d   = dir;
                    half_d  = half_step;
                    rate_d  = rate;
                    rem_d   = steps;
                    presc_d = '0;
                    // Full-step drive runs on even indices only.
                    if (!half_step) idx_d = {idx_q[IW-1:1], 1'b0};
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (presc_q == rate_q) begin
                    tick    = 1'b1;
                    presc_d = '0;
                    rem_d   = rem_q - CNT_W'(1);
                    idx_d   = step_idx(idx_q, dir_q, half_q ? 1 : 2);
                    if (rem_q == CNT_W'(1)) state_d = StDone;
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            presc_q <= '0;
            rate_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            coils_q <= coil_pat(IW'(0));
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            rate_q  <= rate_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            coils_q <= coil_pat(idx_d);
        end
    end

`ifdef GATE_STEPPER_POS_EN
    logic [CNT_W-1:0] pos_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
        end else if (tick) begin
            pos_q <= dir_q ? pos_q - CNT_W'(1) : pos_q + CNT_W'(1);
        end
    end

    assign pos = pos_q;
`endif

    assign busy    = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign dir_out = dir_q;
    assign coils   = coils_q;

endmodule

// File: tb/tb_gate_stepper_ctrl.sv
// Directed self-checking bench for gate_stepper_ctrl (PHASES=4, ACTIVE_LOW=1).
// Define GATE_STEPPER_POS_EN to also exercise the position counter.
module tb_gate_stepper_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, dir, half_step, stop;
    logic [11:0] steps;
    logic [15:0] rate;
    logic        busy, done, dir_out;
    logic [3:0]  coils;
`ifdef GATE_STEPPER_POS_EN
    logic [11:0] pos;
`endif

    int total = 0;
    int bad   = 0;

    gate_stepper_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dir       (dir),
        .steps     (steps),
        .rate      (rate),
        .half_step (half_step),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .dir_out   (dir_out),
`ifdef GATE_STEPPER_POS_EN
        .pos       (pos),
`endif
        .coils     (coils)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle away from the edge.
    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input logic d, input logic [11:0] n, input logic [15:0] r,
                      input logic h);
        start = 1'b1; dir = d; steps = n; rate = r; half_step = h;
        clk_n(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            clk_n(1);
            n++;
        end
        check(tag, 32'(done), 32'h1);
        clk_n(1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; half_step = 1'b0; stop = 1'b0;
        steps = '0; rate = '0;
        clk_n(3);
        rst = 1'b0;
        clk_n(1);
        check("rst_coils", 32'(coils), 32'hE);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dir", 32'(dir_out), 32'h0);

        // Full-step, dir=0, rate=2, 4 steps: tick every 3 cycles.
        go(1'b0, 12'd4, 16'd2, 1'b0);
        check("fs_busy", 32'(busy), 32'h1);
        clk_n(2);
        check("fs_hold", 32'(coils), 32'hE);
        clk_n(1);
        check("fs_t1", 32'(coils), 32'hD);
        clk_n(3);
        check("fs_t2", 32'(coils), 32'hB);
        clk_n(3);
        check("fs_t3", 32'(coils), 32'h7);
        check("fs_busy_mid", 32'(busy), 32'h1);
        clk_n(3);
        check("fs_t4", 32'(coils), 32'hE);
        check("fs_done", 32'(done), 32'h1);
        check("fs_busy_end", 32'(busy), 32'h0);
        clk_n(1);
        check("fs_done_1cyc", 32'(done), 32'h0);

        // Half-step, dir=1, rate=0, 3 steps from idx 0.
        go(1'b1, 12'd3, 16'd0, 1'b1);
        check("hs_start_coils", 32'(coils), 32'hE);
        check("hs_dir_out", 32'(dir_out), 32'h1);
        clk_n(1);
        check("hs_idx7", 32'(coils), 32'h6);
        clk_n(1);
        check("hs_idx6", 32'(coils), 32'h7);
        clk_n(1);
        check("hs_idx5", 32'(coils), 32'h3);
        check("hs_done", 32'(done), 32'h1);
        clk_n(1);
        check("hs_idle", 32'(busy | done), 32'h0);

        // Abort: idx 5 aligns to 4, one tick to 6, stop on the 2nd tick cycle.
        go(1'b0, 12'd10, 16'd5, 1'b0);
        check("ab_align", 32'(coils), 32'hB);
        clk_n(6);
        check("ab_t1", 32'(coils), 32'h7);
        clk_n(5);
        stop = 1'b1;
        clk_n(1);
        stop = 1'b0;
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_coils", 32'(coils), 32'h7);
        for (int i = 0; i < 8; i++) begin
            check("ab_no_done", 32'(done), 32'h0);
            clk_n(1);
        end
        check("ab_hold", 32'(coils), 32'h7);

        // steps=0 is ignored.
        go(1'b0, 12'd0, 16'd0, 1'b1);
        check("z_busy", 32'(busy), 32'h0);
        clk_n(1);
        check("z_done", 32'(done), 32'h0);

        // Start during RUN is ignored: 2 half-steps from idx 6.
        go(1'b0, 12'd2, 16'd0, 1'b1);
        check("rr_busy", 32'(busy), 32'h1);
        start = 1'b1; steps = 12'd10;
        clk_n(1);
        start = 1'b0;
        check("rr_idx7", 32'(coils), 32'h6);
        clk_n(1);
        check("rr_idx0", 32'(coils), 32'hE);
        check("rr_done", 32'(done), 32'h1);
        clk_n(1);
        check("rr_idle", 32'(busy), 32'h0);

`ifdef GATE_STEPPER_POS_EN
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0;
        check("pos_rst", 32'(pos), 32'h0);
        go(1'b0, 12'd5, 16'd0, 1'b0);
        wait_done("pos_fwd_done", 20);
        check("pos_fwd", 32'(pos), 32'd5);
        go(1'b1, 12'd7, 16'd0, 1'b1);
        wait_done("pos_rev_done", 20);
        check("pos_wrap", 32'(pos), 32'd4094);
`else
        go(1'b0, 12'd2, 16'd1, 1'b1);
        wait_done("mv_done", 20);
`endif

        // Asynchronous reset mid-move.
        go(1'b0, 12'd10, 16'd3, 1'b0);
        clk_n(5);
        #2 rst = 1'b1;
        #1;
        check("arst_coils", 32'(coils), 32'hE);
        check("arst_busy", 32'(busy), 32'h0);
`ifdef GATE_STEPPER_POS_EN
        check("arst_pos", 32'(pos), 32'h0);
`endif
        clk_n(1);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
